resp_misr: RTL
==============

// Module: resp_misr
// PURPOSE
//  Clocked response compactor downstream of the parametrizable stimulus generator.
//  - Consumes the exhaustive stimulus sweep (0 .. 2^IN_W-1) and the DUT response
//    to each pattern.
//  - Checks that the stimulus arrives in strict increasing order.
//  - Compresses the responses into a MISR signature and flags completion of the
//    full sweep, so that a bench compares one word instead of every vector.
// PARAMETERS
//  IN_W    4        stimulus width; one sweep = 2^IN_W patterns
//  RESP_W  8        DUT response width; RESP_W <= SIG_W is required
//  SIG_W   16       signature (MISR) width
//  POLY    16'h8005 feedback taps, SIG_W bits wide
//  SEED    16'hFFFF signature value loaded on start, SIG_W bits wide
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous reset, active low
//  start      in   1         begin a new sweep (single-cycle pulse)
//  in_valid   in   1         stimul/resp hold a valid pattern this cycle
//  stimul     in   IN_W      stimulus pattern applied to the DUT
//  resp       in   RESP_W    DUT response to stimul
//  busy       out  1         state == RUN
//  done       out  1         state == DONE; sweep complete, signature final
//  signature  out  SIG_W     MISR contents
//  pat_cnt    out  IN_W+1    number of patterns accepted in the current sweep
//  seq_err    out  1         sticky: a stimulus was out of sequence in this sweep
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=IDLE.
//   - busy, done, seq_err = 0; signature = 0; pat_cnt = 0; internal exp = 0.
//  FSM:
//   - IDLE: start=1 -> RUN. Same edge loads signature=SEED, pat_cnt=0, exp=0,
//     seq_err=0. in_valid is ignored.
//   - RUN: each edge with in_valid=1 accepts one sample:
//       sig = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_ext(resp)
//       pat_cnt++, exp++ (exp wraps modulo 2^IN_W)
//       if stimul != exp: seq_err <= 1 (sticky until next start/reset)
//   - RUN: the sample that makes pat_cnt = 2^IN_W moves state to DONE on the
//     same edge.
//   - RUN: in_valid=0 -> no change. start is ignored in RUN.
//   - DONE: signature, pat_cnt, seq_err held; in_valid ignored. start=1 ->
//     RUN with a fresh load, as from IDLE.
//  Timing and edge cases:
//   - All outputs registered; an accepted sample is visible one cycle after its
//     edge. busy/done reflect the state register.
//   - start and in_valid in the same IDLE/DONE cycle: only start acts; the
//     sample is dropped.
//   - An out-of-order stimulus is still compacted and counted, and the sweep
//     still ends after 2^IN_W samples.
//   - Reset mid-sweep aborts immediately to the reset values; no partial
//     done is produced.
// TESTING (IN_W=2, RESP_W=8, SIG_W=16, POLY=16'h8005, SEED=16'hFFFF)
//  1. Assert rst_n=0 at any time -> busy=0, done=0, seq_err=0,
//     signature=16'h0000, pat_cnt=0.
//  2. Pulse start, then in_valid=1 for 4 cycles with stimul=0,1,2,3, resp=0
//     -> done=1, pat_cnt=3'b100, signature=16'hFFD2, seq_err=0.
//  3. As in 2, but resp=8'h01 on the first sample only -> signature=16'hFFDA.
//  4. As in 2, but stimul=0,1,3,3 -> seq_err=1 from the 3rd sample onward,
//     done=1 after the 4th sample, pat_cnt=4.
//  5. As in 2, with in_valid=0 for 2 cycles between samples 1 and 2 -> result
//     identical to scenario 2; start pulsed mid-RUN is ignored.
//  6. Drop rst_n after 2 samples -> outputs at reset values at once.
//     A new start plus the scenario-2 stimulus -> 16'hFFD2 again.

Source files
------------

// File: rtl/resp_misr.sv
// Response compactor: folds DUT responses from an exhaustive stimulus sweep into
// a MISR signature, checks stimulus ordering and flags completion of the sweep.
module resp_misr #(
  parameter int                IN_W   = 4,
  parameter int                RESP_W = 8,
  parameter int                SIG_W  = 16,
  parameter logic [SIG_W-1:0]  POLY   = 16'h8005,
  parameter logic [SIG_W-1:0]  SEED   = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   stimul,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [IN_W:0]     pat_cnt,
  output logic              seq_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IN_W:0] FULL_CNT = {1'b1, {IN_W{1'b0}}};

  state_t            state_q, state_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [IN_W:0]     cnt_q, cnt_d;
  logic [IN_W-1:0]   exp_q, exp_d;
  logic              err_q, err_d;

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [RESP_W-1:0] r);
    logic [SIG_W-1:0] fb;
    fb = sig[SIG_W-1] ? POLY : {SIG_W{1'b0}};
    return {sig[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(r);
  endfunction

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // A start wins over a coincident sample, which is dropped.
        if (start) begin
          state_d = S_RUN;
          sig_d   = SEED;
          cnt_d   = {(IN_W+1){1'b0}};
          exp_d   = {IN_W{1'b0}};
          err_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          sig_d = misr_step(sig_q, resp);
          cnt_d = cnt_q + (IN_W+1)'(1);
          exp_d = exp_q + IN_W'(1);
          if (stimul != exp_q) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (cnt_d == FULL_CNT) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sig_q   <= {SIG_W{1'b0}};
      cnt_q   <= {(IN_W+1){1'b0}};
      exp_q   <= {IN_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign signature = sig_q;
  assign pat_cnt   = cnt_q;
  assign seq_err   = err_q;

endmodule
